// File: rtl/ccd_timing_pkg.sv
// Shared types and default widths for the CCD clock sequencer.
// Imported by the interface, the phase timer and the top.
package ccd_timing_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned PIX_W_DEF  = 12;
  localparam int unsigned LINE_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_PH2  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_XFER = 3'd5
  } ccd_state_t;

  // Frame configuration at the default widths.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]  half_cyc;
    logic [CNT_W_DEF-1:0]  gap;
    logic [CNT_W_DEF-1:0]  rst_w;
    logic [CNT_W_DEF-1:0]  xfer_w;
    logic [PIX_W_DEF-1:0]  n_pix;
    logic [LINE_W_DEF-1:0] n_lines;
  } cfg_t;

endpackage

// File: rtl/ccd_clock_gen_if.sv
// Control/config/clock bundle between the register bank (master) and the
// CCD clock sequencer (slave).
interface ccd_clock_gen_if #(
  parameter int unsigned CNT_W  = ccd_timing_pkg::CNT_W_DEF,
  parameter int unsigned PIX_W  = ccd_timing_pkg::PIX_W_DEF,
  parameter int unsigned LINE_W = ccd_timing_pkg::LINE_W_DEF
);

  logic              start;
  logic              stop;
  logic              continuous;
  logic [CNT_W-1:0]  half_cyc;
  logic [CNT_W-1:0]  gap;
  logic [CNT_W-1:0]  rst_w;
  logic [CNT_W-1:0]  xfer_w;
  logic [PIX_W-1:0]  n_pix;
  logic [LINE_W-1:0] n_lines;

  logic phi_l1;
  logic phi_l2;
  logic phi_r;
  logic phi_p;
  logic busy;
  logic pix_valid;
  logic line_done;
  logic frame_done;
  logic cfg_err;

  modport master (
    output start, stop, continuous, half_cyc, gap, rst_w, xfer_w, n_pix, n_lines,
    input  phi_l1, phi_l2, phi_r, phi_p, busy, pix_valid, line_done, frame_done, cfg_err
  );

  modport slave (
    input  start, stop, continuous, half_cyc, gap, rst_w, xfer_w, n_pix, n_lines,
    output phi_l1, phi_l2, phi_r, phi_p, busy, pix_valid, line_done, frame_done, cfg_err
  );

endinterface

// File: rtl/ccd_phase_timer.sv
// Loadable down-counter timing each sequencer state; o_last flags the
// final cycle of the loaded duration.
module ccd_phase_timer #(
  parameter int unsigned CNT_W = ccd_timing_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/ccd_clock_gen.sv
// Programmable CCD clock sequencer: serial phases, reset gate and line
// transfer clock with single-frame/continuous modes and strobes.
module ccd_clock_gen
  import ccd_timing_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input logic           clk,
  input logic           rst,
  ccd_clock_gen_if.slave bus
);

  // Same layout as cfg_t, sized by this instance's parameters.
  typedef struct packed {
    logic [CNT_W-1:0]  half_cyc;
    logic [CNT_W-1:0]  gap;
    logic [CNT_W-1:0]  rst_w;
    logic [CNT_W-1:0]  xfer_w;
    logic [PIX_W-1:0]  n_pix;
    logic [LINE_W-1:0] n_lines;
  } lcfg_t;

  ccd_state_t        r_state;
  lcfg_t             r_cfg;
  logic [PIX_W-1:0]  r_pix;
  logic [LINE_W-1:0] r_line;
  logic              r_stop_pend;
  logic r_phi_l1, r_phi_l2, r_phi_r, r_phi_p, r_busy;
  logic r_pix_valid, r_line_done, r_frame_done, r_cfg_err;

  lcfg_t             w_in_cfg;
  lcfg_t             w_cfg_nx;
  logic              w_in_ok;
  logic              w_gap0;
  logic              w_last_pix;
  logic              w_last_line;
  logic              w_stop_any;
  ccd_state_t        w_ns;
  logic              w_load;
  logic [CNT_W-1:0]  w_val;
  logic              w_relatch;
  logic              w_err_nx;
  logic              w_pix_step;
  logic              w_pix_inc;
  logic              w_pix_clr;
  logic              w_line_inc;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_last;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [CNT_W-1:0]  w_rst_eff;
  logic              w_phi_r_nx;
  logic              w_line_done_nx;

  ccd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_val),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  assign w_in_cfg.half_cyc = bus.half_cyc;
  assign w_in_cfg.gap      = bus.gap;
  assign w_in_cfg.rst_w    = bus.rst_w;
  assign w_in_cfg.xfer_w   = bus.xfer_w;
  assign w_in_cfg.n_pix    = bus.n_pix;
  assign w_in_cfg.n_lines  = bus.n_lines;

  assign w_in_ok     = (bus.half_cyc != '0) && (bus.xfer_w != '0) &&
                       (bus.n_pix != '0) && (bus.n_lines != '0);
  assign w_gap0      = (r_cfg.gap == '0);
  assign w_last_pix  = (r_pix == r_cfg.n_pix - PIX_W'(1));
  assign w_last_line = (r_line == r_cfg.n_lines - LINE_W'(1));
  assign w_stop_any  = r_stop_pend | bus.stop;

  always_comb begin
    w_ns       = r_state;
    w_load     = 1'b0;
    w_val      = '0;
    w_relatch  = 1'b0;
    w_err_nx   = 1'b0;
    w_pix_step = 1'b0;
    w_pix_inc  = 1'b0;
    w_pix_clr  = 1'b0;
    w_line_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_in_ok) begin
            w_ns      = ST_PH1;
            w_load    = 1'b1;
            w_val     = bus.half_cyc;
            w_relatch = 1'b1;
          end else begin
            w_err_nx  = 1'b1;
          end
        end
      end
      ST_PH1: begin
        if (w_last) begin
          w_load = 1'b1;
          if (w_gap0) begin
            w_ns  = ST_PH2;
            w_val = r_cfg.half_cyc;
          end else begin
            w_ns  = ST_GAP1;
            w_val = r_cfg.gap;
          end
        end
      end
      ST_GAP1: begin
        if (w_last) begin
          w_ns   = ST_PH2;
          w_load = 1'b1;
          w_val  = r_cfg.half_cyc;
        end
      end
      ST_PH2: begin
        if (w_last) begin
          if (w_gap0) begin
            w_pix_step = 1'b1;
          end else begin
            w_ns   = ST_GAP2;
            w_load = 1'b1;
            w_val  = r_cfg.gap;
          end
        end
      end
      ST_GAP2: begin
        if (w_last) w_pix_step = 1'b1;
      end
      ST_XFER: begin
        if (w_last) begin
          w_load = 1'b1;
          if (!w_last_line) begin
            w_line_inc = 1'b1;
            w_ns       = ST_PH1;
            w_val      = r_cfg.half_cyc;
          end else if (bus.continuous && !w_stop_any && w_in_ok) begin
            w_relatch  = 1'b1;
            w_ns       = ST_PH1;
            w_val      = bus.half_cyc;
          end else begin
            w_err_nx   = bus.continuous && !w_stop_any;
            w_ns       = ST_IDLE;
          end
        end
      end
      default: begin
        w_ns   = ST_IDLE;
        w_load = 1'b1;
      end
    endcase
    // End of a pixel: either the next pixel's PH1 or the line transfer.
    if (w_pix_step) begin
      w_load = 1'b1;
      if (w_last_pix) begin
        w_pix_clr = 1'b1;
        w_ns      = ST_XFER;
        w_val     = r_cfg.xfer_w;
      end else begin
        w_pix_inc = 1'b1;
        w_ns      = ST_PH1;
        w_val     = r_cfg.half_cyc;
      end
    end
  end

  // Outputs are computed for the coming cycle from the next state and the
  // timer value that cycle will hold, so they can all be registered.
  assign w_cfg_nx       = w_relatch ? w_in_cfg : r_cfg;
  assign w_cnt_nx       = w_load ? w_val : (w_cnt - CNT_W'(1));
  assign w_rst_eff      = (w_cfg_nx.rst_w < w_cfg_nx.half_cyc) ? w_cfg_nx.rst_w
                                                               : w_cfg_nx.half_cyc;
  assign w_phi_r_nx     = (w_ns == ST_PH1) &&
                          ((w_cfg_nx.half_cyc - w_cnt_nx) < w_rst_eff);
  assign w_line_done_nx = (w_ns == ST_XFER) && (w_cnt_nx == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cfg        <= '0;
      r_pix        <= '0;
      r_line       <= '0;
      r_stop_pend  <= 1'b0;
      r_phi_l1     <= 1'b0;
      r_phi_l2     <= 1'b0;
      r_phi_r      <= 1'b0;
      r_phi_p      <= 1'b0;
      r_busy       <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state <= w_ns;
      if (w_relatch) begin
        r_cfg  <= w_in_cfg;
        r_pix  <= '0;
        r_line <= '0;
      end else begin
        if (w_pix_clr)      r_pix  <= '0;
        else if (w_pix_inc) r_pix  <= r_pix + PIX_W'(1);
        if (w_line_inc)     r_line <= r_line + LINE_W'(1);
      end
      if (w_ns == ST_IDLE)                          r_stop_pend <= 1'b0;
      else if (bus.stop && (r_state != ST_IDLE))    r_stop_pend <= 1'b1;
      r_phi_l1     <= (w_ns == ST_PH1);
      r_phi_l2     <= (w_ns == ST_PH2);
      r_phi_r      <= w_phi_r_nx;
      r_phi_p      <= (w_ns == ST_XFER);
      r_busy       <= (w_ns != ST_IDLE);
      r_pix_valid  <= (w_ns == ST_PH2) && (w_cnt_nx == CNT_W'(1));
      r_line_done  <= w_line_done_nx;
      r_frame_done <= w_line_done_nx && w_last_line;
      r_cfg_err    <= w_err_nx;
    end
  end

  assign bus.phi_l1     = r_phi_l1;
  assign bus.phi_l2     = r_phi_l2;
  assign bus.phi_r      = r_phi_r;
  assign bus.phi_p      = r_phi_p;
  assign bus.busy       = r_busy;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.line_done  = r_line_done;
  assign bus.frame_done = r_frame_done;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_ccd_clock_gen.sv
// Scoreboard bench for ccd_clock_gen: stimulus queues expected strobe
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_ccd_clock_gen;
  import ccd_timing_pkg::*;

  typedef enum int {EV_PIX, EV_LINE, EV_FRAME, EV_ERR, EV_BUSY} ev_kind_t;
  typedef struct {
    ev_kind_t k;
    int       t;
    int       a;
    int       b;
  } ev_t;

  localparam cfg_t CFG_BASIC = '{half_cyc: 8'd3, gap: 8'd1, rst_w: 8'd1, xfer_w: 8'd4,
                                 n_pix: 12'd2, n_lines: 12'd2};
  localparam cfg_t CFG_NOGAP = '{half_cyc: 8'd2, gap: 8'd0, rst_w: 8'd5, xfer_w: 8'd3,
                                 n_pix: 12'd3, n_lines: 12'd1};
  localparam cfg_t CFG_BADLN = '{half_cyc: 8'd3, gap: 8'd1, rst_w: 8'd1, xfer_w: 8'd4,
                                 n_pix: 12'd2, n_lines: 12'd0};
  localparam cfg_t CFG_WIDE  = '{half_cyc: 8'd1, gap: 8'd0, rst_w: 8'd0, xfer_w: 8'd1,
                                 n_pix: 12'd4095, n_lines: 12'd1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccd_clock_gen_if #(.CNT_W(CNT_W_DEF), .PIX_W(PIX_W_DEF), .LINE_W(LINE_W_DEF)) bus ();

  ccd_clock_gen #(.CNT_W(CNT_W_DEF), .PIX_W(PIX_W_DEF), .LINE_W(LINE_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  t_start = 0;
  int  rel     = 0;
  int  busy_len = 0;
  int  acc_r   = 0;
  int  acc_l1  = 0;

  task automatic expect_ev(input ev_kind_t k, input int t, input int a, input int b);
    ev_t e;
    e.k = k; e.t = t; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  // Expected strobes of one frame starting after frame-relative cycle base.
  task automatic exp_frame(input int unsigned base, input int unsigned half,
                           input int unsigned gap, input int unsigned xfer,
                           input int unsigned npix, input int unsigned nl,
                           input int unsigned rexp);
    int unsigned pix_per;
    int unsigned line_per;
    pix_per  = 2 * half + 2 * gap;
    line_per = npix * pix_per + xfer;
    for (int unsigned l = 0; l < nl; l++) begin
      for (int unsigned p = 0; p < npix; p++)
        expect_ev(EV_PIX, int'(base + l * line_per + p * pix_per + 2 * half + gap),
                  int'(rexp), int'(half));
      expect_ev(EV_LINE, int'(base + (l + 1) * line_per), 0, 0);
      if (l == nl - 1) expect_ev(EV_FRAME, int'(base + (l + 1) * line_per), 0, 0);
    end
  endtask

  task automatic check_ev(input ev_kind_t k, input int t, input int a, input int b);
    ev_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s t=%0d a=%0d b=%0d, required no event", k.name(), t, a, b);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.t != t || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL event: got %s t=%0d a=%0d b=%0d, required %s t=%0d a=%0d b=%0d",
                 k.name(), t, a, b, e.k.name(), e.t, e.a, e.b);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    rel = cyc - t_start;
    n_tests++;
    if ((bus.phi_l1 && bus.phi_l2) || (bus.phi_p && (bus.phi_l1 || bus.phi_l2))) begin
      n_fail++;
      $display("FAIL overlap: l1=%0b l2=%0b p=%0b at t=%0d, required no overlap",
               bus.phi_l1, bus.phi_l2, bus.phi_p, rel);
    end
    acc_r  += int'(bus.phi_r);
    acc_l1 += int'(bus.phi_l1);
    if (bus.pix_valid) begin
      check_ev(EV_PIX, rel, acc_r, acc_l1);
      acc_r  = 0;
      acc_l1 = 0;
    end
    if (bus.line_done)  check_ev(EV_LINE, rel, 0, 0);
    if (bus.frame_done) check_ev(EV_FRAME, rel, 0, 0);
    if (bus.cfg_err)    check_ev(EV_ERR, rel, 0, 0);
    if (bus.busy) begin
      busy_len++;
    end else if (busy_len > 0) begin
      check_ev(EV_BUSY, rel, busy_len, 0);
      busy_len = 0;
      acc_r    = 0;
      acc_l1   = 0;
    end
  end

  task automatic apply_cfg(input cfg_t c);
    bus.half_cyc = c.half_cyc;
    bus.gap      = c.gap;
    bus.rst_w    = c.rst_w;
    bus.xfer_w   = c.xfer_w;
    bus.n_pix    = c.n_pix;
    bus.n_lines  = c.n_lines;
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    bus.start = 1'b1;
    t_start   = cyc;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    for (int i = 0; i < 20000; i++) begin
      if (cyc - t_start >= n) break;
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q.size() == 0 && !bus.busy && busy_len == 0) break;
      @(negedge clk); #1;
    end
    n_tests++;
    if (q.size() != 0 || bus.busy) begin
      n_fail++;
      $display("FAIL drain: pending=%0d busy=%0b, required pending=0 busy=0", q.size(), bus.busy);
      q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic check_all_low(input string name);
    logic [8:0] v;
    v = {bus.phi_l1, bus.phi_l2, bus.phi_r, bus.phi_p, bus.busy,
         bus.pix_valid, bus.line_done, bus.frame_done, bus.cfg_err};
    n_tests++;
    if (v != '0) begin
      n_fail++;
      $display("FAIL %s: outputs=%b, required 000000000", name, v);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0;
    apply_cfg(CFG_BASIC);
    repeat (3) @(negedge clk);
    #1;
    check_all_low("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Basic frame: 40 busy cycles, phi_r one cycle per pixel.
    apply_cfg(CFG_BASIC);
    exp_frame(0, 3, 1, 4, 2, 2, 1);
    expect_ev(EV_BUSY, 41, 40, 0);
    pulse_start();
    wait_idle(300);

    // No gap, phi_r clamped to half_cyc, 4-cycle pixels.
    apply_cfg(CFG_NOGAP);
    exp_frame(0, 2, 0, 3, 3, 1, 2);
    expect_ev(EV_BUSY, 16, 15, 0);
    pulse_start();
    wait_idle(300);

    // Continuous with stop in frame 2: back-to-back frames then idle.
    apply_cfg(CFG_BASIC);
    bus.continuous = 1'b1;
    exp_frame(0, 3, 1, 4, 2, 2, 1);
    exp_frame(40, 3, 1, 4, 2, 2, 1);
    expect_ev(EV_BUSY, 81, 80, 0);
    pulse_start();
    wait_rel(50);
    bus.stop = 1'b1;
    @(negedge clk); #1;
    bus.stop = 1'b0;
    wait_idle(400);
    bus.continuous = 1'b0;

    // Invalid config: single cfg_err, no frame.
    apply_cfg(CFG_BADLN);
    expect_ev(EV_ERR, 1, 0, 0);
    pulse_start();
    wait_rel(3);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_busy: busy=%b, required 0", bus.busy);
    end
    wait_idle(50);

    // start while busy with garbage inputs: frame unchanged, no cfg_err.
    apply_cfg(CFG_BASIC);
    exp_frame(0, 3, 1, 4, 2, 2, 1);
    expect_ev(EV_BUSY, 41, 40, 0);
    pulse_start();
    wait_rel(10);
    apply_cfg(CFG_BADLN);
    bus.half_cyc = 8'd7;
    bus.gap      = 8'd0;
    bus.start    = 1'b1;
    @(negedge clk); #1;
    bus.start    = 1'b0;
    wait_idle(300);

    // Reset during XFER of line 0, then a clean full frame.
    apply_cfg(CFG_BASIC);
    expect_ev(EV_PIX, 7, 1, 3);
    expect_ev(EV_PIX, 15, 1, 3);
    expect_ev(EV_BUSY, 19, 18, 0);
    pulse_start();
    wait_rel(18);
    rst = 1'b1;
    #1;
    check_all_low("reset_mid_xfer");
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    wait_idle(50);
    exp_frame(0, 3, 1, 4, 2, 2, 1);
    expect_ev(EV_BUSY, 41, 40, 0);
    pulse_start();
    wait_idle(300);

    // Maximum pixel count per line.
    apply_cfg(CFG_WIDE);
    exp_frame(0, 1, 0, 1, 4095, 1, 0);
    expect_ev(EV_BUSY, 8192, 8191, 0);
    pulse_start();
    wait_idle(9000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
